// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : CPU data-memory responder; fixed-latency single-word access
//               with a one-cycle ready pulse, conflict error and op counters.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 d_readM,
  input  logic                 d_writeM,
  input  logic [WORD_SIZE-1:0] d_address,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_ready,
  output logic                 d_err,
  output logic [WORD_SIZE-1:0] num_read,
  output logic [WORD_SIZE-1:0] num_write
);

  localparam int                   c_depth    = 1 << ADDR_BITS;
  localparam logic [3:0]           c_cnt_load = 4'(LATENCY - 1);
  localparam logic [WORD_SIZE-1:0] c_cnt_max  = '1;
  localparam logic [WORD_SIZE-1:0] c_one      = {{(WORD_SIZE-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [3:0]             r_cnt, w_cnt_nxt;
  logic                   r_is_wr;
  logic [ADDR_BITS-1:0]   r_addr;
  logic [WORD_SIZE-1:0]   r_wdata;
  logic [WORD_SIZE-1:0]   r_mem [0:c_depth-1];
  logic [WORD_SIZE-1:0]   r_rdata, r_num_read, r_num_write;
  logic                   r_ready, r_err;

  logic                   w_req_one, w_req_both;
  logic                   w_accept, w_enter_resp, w_err_nxt;
  logic                   w_cur_is_wr;
  logic [ADDR_BITS-1:0]   w_cur_addr;
  logic [WORD_SIZE-1:0]   w_cur_wdata;

  assign w_req_one  = d_readM ^ d_writeM;
  assign w_req_both = d_readM & d_writeM;

  // With LATENCY=1 the access completes on the accept edge itself, so the
  // operands come straight from the inputs instead of the capture registers.
  assign w_cur_is_wr = (r_state == S_IDLE) ? d_writeM                    : r_is_wr;
  assign w_cur_addr  = (r_state == S_IDLE) ? d_address[ADDR_BITS-1:0]    : r_addr;
  assign w_cur_wdata = (r_state == S_IDLE) ? d_wdata                     : r_wdata;

  if (ADDR_BITS < WORD_SIZE) begin : g_addr_hi
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = ^d_address[WORD_SIZE-1:ADDR_BITS];
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_accept     = 1'b0;
    w_enter_resp = 1'b0;
    w_err_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req_one) begin
          w_accept  = 1'b1;
          w_cnt_nxt = c_cnt_load;
          if (c_cnt_load == 4'd0) begin
            w_state_nxt  = S_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_nxt = S_BUSY;
          end
        end else if (w_req_both) begin
          w_err_nxt = 1'b1;
        end
      end
      S_BUSY: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_nxt  = S_RESP;
          w_enter_resp = 1'b1;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_ready     <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_num_read  <= '0;
      r_num_write <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= w_enter_resp;
      r_err   <= w_err_nxt;
      if (w_enter_resp) begin
        if (w_cur_is_wr) begin
          if (r_num_write != c_cnt_max) r_num_write <= r_num_write + c_one;
        end else begin
          r_rdata <= r_mem[w_cur_addr];
          if (r_num_read != c_cnt_max) r_num_read <= r_num_read + c_one;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_is_wr <= d_writeM;
      r_addr  <= d_address[ADDR_BITS-1:0];
      r_wdata <= d_wdata;
    end
  end

  // Gating on reset drops a write whose commit edge coincides with reset.
  always_ff @(posedge clk) begin
    if (!reset && w_enter_resp && w_cur_is_wr) r_mem[w_cur_addr] <= w_cur_wdata;
  end

  assign d_rdata   = r_rdata;
  assign d_ready   = r_ready;
  assign d_err     = r_err;
  assign num_read  = r_num_read;
  assign num_write = r_num_write;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Directed self-checking bench for data_mem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // LATENCY=2 instance
  logic        rd2, wr2, rdy2, err2;
  logic [15:0] addr2, wd2, rdata2, nr2, nw2;
  // LATENCY=1 instance
  logic        rd1, wr1, rdy1, err1;
  logic [15:0] addr1, wd1, rdata1, nr1, nw1;
  // narrow instance for counter saturation
  logic        rd3, wr3, rdy3, err3;
  logic [3:0]  addr3, wd3, rdata3, nr3, nw3;

  data_mem_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .LATENCY(2)) dut2 (
    .clk(clk), .reset(rst), .d_readM(rd2), .d_writeM(wr2), .d_address(addr2),
    .d_wdata(wd2), .d_rdata(rdata2), .d_ready(rdy2), .d_err(err2),
    .num_read(nr2), .num_write(nw2));

  data_mem_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .LATENCY(1)) dut1 (
    .clk(clk), .reset(rst), .d_readM(rd1), .d_writeM(wr1), .d_address(addr1),
    .d_wdata(wd1), .d_rdata(rdata1), .d_ready(rdy1), .d_err(err1),
    .num_read(nr1), .num_write(nw1));

  data_mem_responder #(.WORD_SIZE(4), .ADDR_BITS(2), .LATENCY(1)) dut3 (
    .clk(clk), .reset(rst), .d_readM(rd3), .d_writeM(wr3), .d_address(addr3),
    .d_wdata(wd3), .d_rdata(rdata3), .d_ready(rdy3), .d_err(err3),
    .num_read(nr3), .num_write(nw3));

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        exp_err;
    logic [15:0] exp_rdata;
    logic [15:0] exp_nr;
    logic [15:0] exp_nw;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One access on the LATENCY=2 instance, with latency and pulse-width checks.
  task automatic run_vec(input vec_t v, input string name);
    int n;
    logic got_rdy, got_err;
    @(negedge clk);
    rd2 = v.rd; wr2 = v.wr; addr2 = v.addr; wd2 = v.wdata;
    n = 0; got_rdy = 1'b0; got_err = 1'b0;
    while (!got_rdy && !got_err && n < 20) begin
      @(negedge clk);
      n++;
      got_rdy = rdy2;
      got_err = err2;
    end
    rd2 = 1'b0; wr2 = 1'b0;
    chk({name, "_lat"}, n, v.exp_err ? 1 : 2);
    chk({name, "_rdy"}, {31'd0, rdy2}, {31'd0, ~v.exp_err});
    chk({name, "_err"}, {31'd0, err2}, {31'd0, v.exp_err});
    chk({name, "_rdata"}, rdata2, v.exp_rdata);
    chk({name, "_nr"}, nr2, v.exp_nr);
    chk({name, "_nw"}, nw2, v.exp_nw);
    @(negedge clk);
    chk({name, "_pulse"}, {30'd0, rdy2, err2}, 0);
  endtask

  vec_t vecs [10];

  initial begin
    int pulses, first_k, n;
    logic [15:0] pre_val [3];

    vecs[0] = '{rd:0, wr:1, addr:16'h0010, wdata:16'hBEEF, exp_err:0, exp_rdata:16'h0BAD, exp_nr:1, exp_nw:1};
    vecs[1] = '{rd:1, wr:0, addr:16'h0010, wdata:16'h0000, exp_err:0, exp_rdata:16'hBEEF, exp_nr:2, exp_nw:1};
    vecs[2] = '{rd:1, wr:1, addr:16'h0010, wdata:16'h1111, exp_err:1, exp_rdata:16'hBEEF, exp_nr:2, exp_nw:1};
    vecs[3] = '{rd:1, wr:0, addr:16'h0010, wdata:16'h0000, exp_err:0, exp_rdata:16'hBEEF, exp_nr:3, exp_nw:1};
    vecs[4] = '{rd:0, wr:1, addr:16'h0105, wdata:16'hA5A5, exp_err:0, exp_rdata:16'hBEEF, exp_nr:3, exp_nw:2};
    vecs[5] = '{rd:1, wr:0, addr:16'h0005, wdata:16'h0000, exp_err:0, exp_rdata:16'hA5A5, exp_nr:4, exp_nw:2};
    vecs[6] = '{rd:0, wr:1, addr:16'h00FF, wdata:16'h0001, exp_err:0, exp_rdata:16'hA5A5, exp_nr:4, exp_nw:3};
    vecs[7] = '{rd:1, wr:0, addr:16'h00FF, wdata:16'h0000, exp_err:0, exp_rdata:16'h0001, exp_nr:5, exp_nw:3};
    vecs[8] = '{rd:1, wr:0, addr:16'hFF10, wdata:16'h0000, exp_err:0, exp_rdata:16'hBEEF, exp_nr:6, exp_nw:3};
    vecs[9] = '{rd:0, wr:1, addr:16'h0030, wdata:16'h3030, exp_err:0, exp_rdata:16'hBEEF, exp_nr:6, exp_nw:4};
    pre_val[0] = 16'h1000; pre_val[1] = 16'h2001; pre_val[2] = 16'h3002;

    rst = 1'b1;
    rd2 = 0; wr2 = 0; addr2 = 0; wd2 = 0;
    rd1 = 0; wr1 = 0; addr1 = 0; wd1 = 0;
    rd3 = 0; wr3 = 0; addr3 = 0; wd3 = 0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", {31'd0, rdy2}, 0);
    chk("rst_err", {31'd0, err2}, 0);
    chk("rst_rdata", rdata2, 0);
    chk("rst_nr", nr2, 0);
    chk("rst_nw", nw2, 0);
    rst = 1'b0;

    // Reset in the middle of a write must discard it.
    run_vec('{rd:0, wr:1, addr:16'h0003, wdata:16'h0BAD, exp_err:0, exp_rdata:16'h0000, exp_nr:0, exp_nw:1}, "pre");
    @(negedge clk);
    wr2 = 1'b1; addr2 = 16'h0003; wd2 = 16'h1234;
    @(negedge clk);
    chk("rb_busy_rdy", {31'd0, rdy2}, 0);
    rst = 1'b1; wr2 = 1'b0;
    @(negedge clk);
    chk("rb_rdy", {31'd0, rdy2}, 0);
    chk("rb_nr", nr2, 0);
    chk("rb_nw", nw2, 0);
    chk("rb_rdata", rdata2, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rb_late_rdy", {31'd0, rdy2}, 0);
    run_vec('{rd:1, wr:0, addr:16'h0003, wdata:16'h0000, exp_err:0, exp_rdata:16'h0BAD, exp_nr:1, exp_nw:0}, "rb_read");

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Inputs changed and request dropped while BUSY: captured write still commits.
    @(negedge clk);
    wr2 = 1'b1; addr2 = 16'h0020; wd2 = 16'h7777;
    @(negedge clk);
    addr2 = 16'h0030; wd2 = 16'h9999; wr2 = 1'b0;
    pulses = 0; first_k = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (rdy2) begin
        pulses++;
        if (first_k == 0) first_k = k;
      end
    end
    chk("chg_pulses", pulses, 1);
    chk("chg_when", first_k, 1);
    chk("chg_nw", nw2, 5);
    chk("chg_rdata", rdata2, 16'hBEEF);
    run_vec('{rd:1, wr:0, addr:16'h0020, wdata:16'h0000, exp_err:0, exp_rdata:16'h7777, exp_nr:7, exp_nw:5}, "chg_rd20");
    run_vec('{rd:1, wr:0, addr:16'h0030, wdata:16'h0000, exp_err:0, exp_rdata:16'h3030, exp_nr:8, exp_nw:5}, "chg_rd30");

    // LATENCY=1: preload then back-to-back reads with d_readM held.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wr1 = 1'b1; addr1 = 16'(i); wd1 = pre_val[i];
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!rdy1 && n < 10);
      wr1 = 1'b0;
      chk($sformatf("l1_wr%0d_lat", i), n, 1);
    end
    @(negedge clk);
    rd1 = 1'b1; addr1 = 16'h0000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("l1_rdy%0d", k), {31'd0, rdy1}, (k % 2 == 0) ? 1 : 0);
      if (k % 2 == 0) begin
        chk($sformatf("l1_rdata%0d", k / 2), rdata1, pre_val[k / 2]);
        addr1 = 16'(k / 2 + 1);
      end
    end
    rd1 = 1'b0;
    chk("l1_nr", nr1, 3);
    chk("l1_nw", nw1, 3);

    // Narrow counters must stop at all-ones.
    @(negedge clk);
    rd3 = 1'b1; addr3 = 4'd0;
    repeat (40) @(negedge clk);
    rd3 = 1'b0;
    repeat (2) @(negedge clk);
    chk("sat_nr", {28'd0, nr3}, 32'hF);
    chk("sat_nw", {28'd0, nw3}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
